// File: rtl/matmul_pkg.sv
// Shared types and default widths for the SRAM-backed fixed-point matrix-multiply engine.
package matmul_pkg;
   localparam int DATA_W      = 16;
   localparam int FRAC_BITS   = 8;
   localparam int ACC_W       = 48;
   localparam int DIM_W       = 16;
   localparam int ADDR_W      = 14;
   localparam int SRAM_WORD_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_A,
      ST_RD_B,
      ST_MAC,
      ST_WR,
      ST_DONE
   } mm_state_t;
endpackage

// File: rtl/fxp_shift_sat.sv
// Arithmetic right shift of a wide accumulator into DATA_W bits, clamping to the
// signed range and flagging any clamp.
module fxp_shift_sat #(
   parameter int ACC_W     = 48,
   parameter int DATA_W    = 16,
   parameter int FRAC_BITS = 8
) (
   input  logic signed [ACC_W-1:0]  i_acc,
   output logic signed [DATA_W-1:0] o_val,
   output logic                     o_ovf
);
   localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   logic signed [ACC_W-1:0] w_shift;

   assign w_shift = i_acc >>> FRAC_BITS;

   always_comb begin
      o_ovf = 1'b0;
      o_val = w_shift[DATA_W-1:0];
      if (w_shift > MAX_V) begin
         o_val = MAX_V[DATA_W-1:0];
         o_ovf = 1'b1;
      end else if (w_shift < MIN_V) begin
         o_val = MIN_V[DATA_W-1:0];
         o_ovf = 1'b1;
      end
   end
endmodule

// File: rtl/matmul_sram_engine.sv
// C = A x B over row-major operands in SRAM; one element per 3K+1 cycles using a
// single MAC and running address pointers instead of multipliers.
module matmul_sram_engine #(
   parameter int DATA_W    = matmul_pkg::DATA_W,
   parameter int FRAC_BITS = matmul_pkg::FRAC_BITS,
   parameter int ACC_W     = matmul_pkg::ACC_W,
   parameter int DIM_W     = matmul_pkg::DIM_W,
   parameter int ADDR_W    = matmul_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [DIM_W-1:0]  m_dim,
   input  logic [DIM_W-1:0]  k_dim,
   input  logic [DIM_W-1:0]  n_dim,
   input  logic [ADDR_W-1:0] a_base,
   input  logic [ADDR_W-1:0] b_base,
   input  logic [ADDR_W-1:0] c_base,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              sat,
   output logic [ADDR_W-1:0] address,
   output logic              chip_select,
   output logic              clk_en,
   output logic              read,
   output logic              write,
   output logic [31:0]       write_data,
   output logic [3:0]        byte_enable,
   input  logic [31:0]       read_data
);
   import matmul_pkg::*;

   mm_state_t               r_state;
   logic [DIM_W-1:0]        r_m, r_k_dim, r_n;
   logic [DIM_W-1:0]        r_i, r_j, r_k;
   logic [ADDR_W-1:0]       r_a_row, r_a_ptr, r_b_col, r_b_ptr, r_b_base, r_c_ptr;
   logic signed [ACC_W-1:0] r_acc;
   logic signed [DATA_W-1:0] r_a;
   logic                    r_busy, r_done, r_err, r_sat, r_cs, r_read, r_write;
   logic [ADDR_W-1:0]       r_address;
   logic [31:0]             r_write_data;
   logic [3:0]              r_byte_en;

   logic signed [DATA_W-1:0]   w_b;
   logic signed [2*DATA_W-1:0] w_prod;
   logic signed [ACC_W-1:0]    w_prod_ext, w_acc_next;
   logic signed [DATA_W-1:0]   w_sat_val;
   logic                       w_ovf;
   logic                       w_k_last, w_j_last, w_i_last;
   logic [ADDR_W-1:0]          w_k_step, w_n_step;
   logic                       w_unused_hi;

   assign w_b        = signed'(read_data[DATA_W-1:0]);
   assign w_prod     = r_a * w_b;
   assign w_prod_ext = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
   assign w_acc_next = r_acc + w_prod_ext;
   assign w_unused_hi = ^read_data[31:DATA_W];

   assign w_k_last = (r_k == r_k_dim - DIM_W'(1));
   assign w_j_last = (r_j == r_n - DIM_W'(1));
   assign w_i_last = (r_i == r_m - DIM_W'(1));
   // Pointer steps wrap at the SRAM size, so truncating the dimension is exact.
   assign w_k_step = ADDR_W'(r_k_dim);
   assign w_n_step = ADDR_W'(r_n);

   fxp_shift_sat #(
      .ACC_W    (ACC_W),
      .DATA_W   (DATA_W),
      .FRAC_BITS(FRAC_BITS)
   ) u_shift_sat (
      .i_acc(w_acc_next),
      .o_val(w_sat_val),
      .o_ovf(w_ovf)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_m          <= '0;
         r_k_dim      <= '0;
         r_n          <= '0;
         r_i          <= '0;
         r_j          <= '0;
         r_k          <= '0;
         r_a_row      <= '0;
         r_a_ptr      <= '0;
         r_b_col      <= '0;
         r_b_ptr      <= '0;
         r_b_base     <= '0;
         r_c_ptr      <= '0;
         r_acc        <= '0;
         r_a          <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_sat        <= 1'b0;
         r_cs         <= 1'b0;
         r_read       <= 1'b0;
         r_write      <= 1'b0;
         r_address    <= '0;
         r_write_data <= '0;
         r_byte_en    <= '0;
      end else begin
         r_done    <= 1'b0;
         r_cs      <= 1'b0;
         r_read    <= 1'b0;
         r_write   <= 1'b0;
         r_byte_en <= 4'h0;
         if (abort && r_busy) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (start && !abort) begin
                     r_m      <= m_dim;
                     r_k_dim  <= k_dim;
                     r_n      <= n_dim;
                     r_i      <= '0;
                     r_j      <= '0;
                     r_k      <= '0;
                     r_a_row  <= a_base;
                     r_a_ptr  <= a_base;
                     r_b_col  <= b_base;
                     r_b_ptr  <= b_base;
                     r_b_base <= b_base;
                     r_c_ptr  <= c_base;
                     r_acc    <= '0;
                     r_sat    <= 1'b0;
                     if (m_dim == '0 || k_dim == '0 || n_dim == '0) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                     end else begin
                        r_state   <= ST_RD_A;
                        r_err     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_cs      <= 1'b1;
                        r_read    <= 1'b1;
                        r_address <= a_base;
                     end
                  end
               end
               ST_RD_A: begin
                  r_state   <= ST_RD_B;
                  r_cs      <= 1'b1;
                  r_read    <= 1'b1;
                  r_address <= r_b_ptr;
               end
               ST_RD_B: begin
                  r_a     <= signed'(read_data[DATA_W-1:0]);
                  r_state <= ST_MAC;
               end
               ST_MAC: begin
                  r_acc <= w_acc_next;
                  if (w_k_last) begin
                     r_state      <= ST_WR;
                     r_cs         <= 1'b1;
                     r_write      <= 1'b1;
                     r_address    <= r_c_ptr;
                     r_write_data <= {{(32-DATA_W){w_sat_val[DATA_W-1]}}, w_sat_val};
                     r_byte_en    <= 4'hF;
                     if (w_ovf) r_sat <= 1'b1;
                  end else begin
                     r_state   <= ST_RD_A;
                     r_k       <= r_k + DIM_W'(1);
                     r_a_ptr   <= r_a_ptr + ADDR_W'(1);
                     r_b_ptr   <= r_b_ptr + w_n_step;
                     r_cs      <= 1'b1;
                     r_read    <= 1'b1;
                     r_address <= r_a_ptr + ADDR_W'(1);
                  end
               end
               ST_WR: begin
                  r_acc   <= '0;
                  r_k     <= '0;
                  r_c_ptr <= r_c_ptr + ADDR_W'(1);
                  if (w_j_last && w_i_last) begin
                     r_state <= ST_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= ST_RD_A;
                     r_cs    <= 1'b1;
                     r_read  <= 1'b1;
                     if (w_j_last) begin
                        // Next row of A, back to the first column of B.
                        r_i       <= r_i + DIM_W'(1);
                        r_j       <= '0;
                        r_a_row   <= r_a_row + w_k_step;
                        r_a_ptr   <= r_a_row + w_k_step;
                        r_b_col   <= r_b_base;
                        r_b_ptr   <= r_b_base;
                        r_address <= r_a_row + w_k_step;
                     end else begin
                        r_j       <= r_j + DIM_W'(1);
                        r_a_ptr   <= r_a_row;
                        r_b_col   <= r_b_col + ADDR_W'(1);
                        r_b_ptr   <= r_b_col + ADDR_W'(1);
                        r_address <= r_a_row;
                     end
                  end
               end
               ST_DONE: r_state <= ST_IDLE;
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign err         = r_err;
   assign sat         = r_sat;
   assign address     = r_address;
   assign chip_select = r_cs;
   assign clk_en      = r_cs;
   assign read        = r_read;
   assign write       = r_write;
   assign write_data  = r_write_data;
   assign byte_enable = r_byte_en;
endmodule
